// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath and its central sequencer.
// The sequencer (slave) receives hazard/memory status and returns stage
// enables, bubble controls, halt status and the stall counter.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             idex_memread;
    logic [3:0]       idex_rd;
    logic [3:0]       ifid_rs;
    logic [3:0]       ifid_rt;
    logic             ifid_rt_used;
    logic             branch_taken;
    logic             hlt_id;
    logic             memwb_hlt;
    logic             imem_busy;
    logic             dmem_busy;

    logic             pc_wen;
    logic             ifid_wen;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_wen;
    logic             memwb_wen;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_rt_used,
               branch_taken, hlt_id, memwb_hlt, imem_busy, dmem_busy,
        input  pc_wen, ifid_wen, ifid_flush, idex_flush, exmem_wen,
               memwb_wen, halted, stall_cycles
    );

    modport slave (
        input  idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_rt_used,
               branch_taken, hlt_id, memwb_hlt, imem_busy, dmem_busy,
        output pc_wen, ifid_wen, ifid_flush, idex_flush, exmem_wen,
               memwb_wen, halted, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the five-stage pipeline: stage write enables and
// bubble controls from hazards, branches, memory busy and HLT, plus the
// halt-drain state machine and a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_pc_wen;
    logic w_ifid_wen;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_wen;
    logic w_memwb_wen;
    logic w_halted;

    // A load in EX whose destination feeds the instruction in ID; r0 never hazards.
    assign w_load_use = bus.idex_memread & (bus.idex_rd != 4'h0) &
                        ((bus.idex_rd == bus.ifid_rs) |
                         (bus.ifid_rt_used & (bus.idex_rd == bus.ifid_rt)));

    // State register; reset returns straight to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prioritised stage controls and halt-sequencing next state.
    always_comb begin
        w_pc_wen     = 1'b1;
        w_ifid_wen   = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_exmem_wen  = 1'b1;
        w_memwb_wen  = 1'b1;
        w_halted     = 1'b0;
        w_state_nxt  = r_state;

        if (!rst) begin
            // While reset is held the pipeline free-runs with no bubbles.
            w_state_nxt = RUN;
        end else if (r_state == HALTED) begin
            w_pc_wen    = 1'b0;
            w_ifid_wen  = 1'b0;
            w_exmem_wen = 1'b0;
            w_memwb_wen = 1'b0;
            w_halted    = 1'b1;
        end else if (bus.dmem_busy) begin
            // Full freeze: nothing moves, state holds.
            w_pc_wen    = 1'b0;
            w_ifid_wen  = 1'b0;
            w_exmem_wen = 1'b0;
            w_memwb_wen = 1'b0;
        end else begin
            if (w_load_use) begin
                // Hold PC and IF/ID, bubble into EX; a same-cycle branch is
                // dropped and re-resolved next cycle with forwarded data.
                w_pc_wen     = 1'b0;
                w_ifid_wen   = 1'b0;
                w_idex_flush = 1'b1;
            end else if (r_state == DRAIN) begin
                w_pc_wen     = 1'b0;
                w_ifid_flush = 1'b1;
            end else if (bus.branch_taken) begin
                // Redirect wins over a pending fetch, which is abandoned.
                w_ifid_flush = 1'b1;
            end else if (bus.imem_busy) begin
                w_pc_wen     = 1'b0;
                w_ifid_flush = 1'b1;
            end

            case (r_state)
                RUN:     if (bus.hlt_id && !w_load_use) w_state_nxt = DRAIN;
                DRAIN:   if (bus.memwb_hlt)             w_state_nxt = HALTED;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // Stall counter: counts PC-held cycles outside HALTED, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state != HALTED) && !w_pc_wen && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign bus.pc_wen       = w_pc_wen;
    assign bus.ifid_wen     = w_ifid_wen;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_flush   = w_idex_flush;
    assign bus.exmem_wen    = w_exmem_wen;
    assign bus.memwb_wen    = w_memwb_wen;
    assign bus.halted       = w_halted;
    assign bus.stall_cycles = r_stall_cnt;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage write-enable and flush (bubble) controls from four inputs: load-use hazards, taken branches, instruction/data memory busy, and HLT.
- Owns the halt-drain state machine and a saturating stall counter used for performance debug.

Parameters:
- CNT_W, 16, width of the stall_cycles counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-low (0 = reset)
- idex_memread  input  1  instruction in ID/EX is a load
- idex_rd  input  4  destination register of ID/EX instruction
- ifid_rs  input  4  source register 1 of IF/ID instruction
- ifid_rt  input  4  source register 2 of IF/ID instruction
- ifid_rt_used  input  1  IF/ID instruction reads rt
- branch_taken  input  1  branch in ID resolved taken this cycle
- hlt_id  input  1  IF/ID instruction is HLT
- memwb_hlt  input  1  HLT_Out from MEM/WB
- imem_busy  input  1  instruction fetch not complete this cycle
- dmem_busy  input  1  data memory access not complete this cycle
- pc_wen  output  1  PC register write enable
- ifid_wen  output  1  IF/ID write enable
- ifid_flush  output  1  IF/ID loads NOP (bubble) instead of fetched word
- idex_flush  output  1  ID/EX loads zero control (bubble)
- exmem_wen  output  1  EX/MEM write enable
- memwb_wen  output  1  MEM/WB write enable
- halted  output  1  core halted
- stall_cycles  output  CNT_W  count of cycles with pc_wen=0 while not HALTED

Behaviour:
- State register: RUN=2'b00, DRAIN=2'b01, HALTED=2'b10. Reset (rst=0, async) -> RUN, stall_cycles=0.
- Outputs are combinational from state and inputs. During reset: pc_wen=ifid_wen=exmem_wen=memwb_wen=1, flushes=0, halted=0.
- load_use = idex_memread & (idex_rd!=0) & ((idex_rd==ifid_rs) | (ifid_rt_used & idex_rd==ifid_rt)).
- Priority, highest first:
  1. HALTED: all wen=0, flushes=0, halted=1. Exit only via reset.
  2. dmem_busy: full freeze; all wen=0, flushes=0. No state change except stall count. Overrides branch, load_use and imem_busy.
  3. load_use: pc_wen=0, ifid_wen=0, idex_flush=1, exmem/memwb_wen=1. branch_taken in the same cycle is ignored; the branch is re-evaluated next cycle with forwarded data.
  4. branch_taken: pc_wen=1 (redirect; any in-flight fetch is abandoned even if imem_busy), ifid_wen=1, ifid_flush=1, others advance.
  5. imem_busy: pc_wen=0, ifid_wen=1, ifid_flush=1, others advance.
  6. Otherwise: all wen=1, flushes=0.
- Halt sequencing:
  - RUN & hlt_id & no freeze/load_use -> DRAIN next edge. HLT is allowed into ID/EX.
  - DRAIN forces pc_wen=0, ifid_wen=1, ifid_flush=1 every non-frozen cycle; downstream stages advance; rules 2-3 still apply.
  - DRAIN & memwb_hlt -> HALTED next edge. memwb_hlt in RUN is ignored (cannot occur legally).
  - Latency: with no memory stalls, halted asserts exactly 4 cycles after the first cycle hlt_id=1.
- stall_cycles: increments by 1 on each edge where state!=HALTED and pc_wen=0. Saturates at all-ones (no wrap). Cleared only by reset.
- Reset mid-drain or mid-stall returns immediately to RUN with the counter cleared.
- No X on outputs for any input combination. Inputs are assumed synchronous to clk.

Test Plan:
- Load-use: idex_memread=1, idex_rd=4'h3, ifid_rs=4'h3 for 1 cycle -> pc_wen=0, ifid_wen=0, idex_flush=1; stall_cycles 0->1. Same with idex_rd=0 -> no stall.
- Branch vs load-use collision: branch_taken=1 with load_use true -> no ifid_flush, pc_wen=0. Next cycle branch_taken=1 alone -> pc_wen=1, ifid_flush=1.
- dmem_busy held 3 cycles during branch_taken and imem_busy -> all wen=0, flushes=0 for 3 cycles; stall_cycles +3.
- Halt drain: hlt_id pulse at cycle N, memwb_hlt at N+3 -> DRAIN at N+1, halted=1 from N+4, all wen=0 thereafter; stall_cycles stops incrementing once HALTED.
- Halt with dmem_busy 2 cycles in DRAIN -> halted delayed by exactly 2 cycles.
- Async reset: drop rst mid-DRAIN between clock edges -> outputs return to reset values immediately; after release, state=RUN and stall_cycles=0. Saturation: preload by holding imem_busy for 2^CNT_W+5 cycles -> counter holds at all-ones.
